// File: rtl/msb_pkg.sv
// Shared definitions for the multi-stream buffer read path.
package msb_pkg;

  localparam int ST_WIDTH = 4;
  localparam int CL_WIDTH = 4;
  localparam int OF_WIDTH = 3;

  // One read request as presented to the BRAM read port.
  typedef struct packed {
    logic [ST_WIDTH-1:0] st;
    logic [CL_WIDTH-1:0] cl;
    logic [OF_WIDTH-1:0] of;
  } msb_rd_req_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int tag_width(input int n_req);
    return (n_req <= 2) ? 1 : $clog2(n_req);
  endfunction

endpackage

// File: rtl/msb_tag_fifo.sv
// Grant-order tag FIFO. Its occupancy doubles as the outstanding-read count,
// so the arbiter never pushes when full and never pops when empty.
module msb_tag_fifo #(
  parameter int TAG_W = 2,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [TAG_W-1:0]           tag_in,
  input  logic                       pop,
  output logic [TAG_W-1:0]           head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; stored tags need no reset because the pointers do.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage write.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tag_in;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/msb_read_arbiter.sv
// Round-robin arbiter sharing the BRAM read port among N_REQ requesters.
// Grants land in a registered issue stage; a tag FIFO remembers grant order
// so returning data is steered back to its requester with no added latency.
module msb_read_arbiter #(
  parameter int N_REQ        = 4,
  parameter int ST_WIDTH     = msb_pkg::ST_WIDTH,
  parameter int CL_WIDTH     = msb_pkg::CL_WIDTH,
  parameter int OF_WIDTH     = msb_pkg::OF_WIDTH,
  parameter int DATA_WIDTH   = 128,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                            clk1x,
  input  logic                            reset,
  input  logic [N_REQ-1:0]                req_v,
  output logic [N_REQ-1:0]                req_r,
  input  logic [N_REQ*ST_WIDTH-1:0]       req_st,
  input  logic [N_REQ*CL_WIDTH-1:0]       req_cl,
  input  logic [N_REQ*OF_WIDTH-1:0]       req_of,
  output logic                            m_v,
  input  logic                            m_r,
  output logic [ST_WIDTH-1:0]             m_ra_st,
  output logic [CL_WIDTH-1:0]             m_ra_cl,
  output logic [OF_WIDTH-1:0]             m_ra_of,
  input  logic                            s_v,
  output logic                            s_r,
  input  logic [DATA_WIDTH-1:0]           s_rd,
  output logic [N_REQ-1:0]                rsp_v,
  input  logic [N_REQ-1:0]                rsp_r,
  output logic [DATA_WIDTH-1:0]           rsp_d,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight,
  output logic                            err
);

  import msb_pkg::*;

  localparam int               TAG_W   = tag_width(N_REQ);
  localparam int               CNT_W   = $clog2(MAX_INFLIGHT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
  localparam logic [TAG_W-1:0] PTR_RST = TAG_W'(N_REQ - 1);

  logic [ST_WIDTH-1:0] st_arr [N_REQ];
  logic [CL_WIDTH-1:0] cl_arr [N_REQ];
  logic [OF_WIDTH-1:0] of_arr [N_REQ];

  logic [TAG_W-1:0]    ptr_q, ptr_d;
  logic                m_v_q, m_v_d;
  logic [ST_WIDTH-1:0] st_q, st_d;
  logic [CL_WIDTH-1:0] cl_q, cl_d;
  logic [OF_WIDTH-1:0] of_q, of_d;
  logic                err_q, err_d;

  logic                grant_en, grant_found, grant, pop, fifo_empty;
  logic [TAG_W-1:0]    grant_idx, head;
  logic [CNT_W-1:0]    count;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign st_arr[gi] = req_st[gi*ST_WIDTH +: ST_WIDTH];
      assign cl_arr[gi] = req_cl[gi*CL_WIDTH +: CL_WIDTH];
      assign of_arr[gi] = req_of[gi*OF_WIDTH +: OF_WIDTH];
      assign req_r[gi]  = grant && (grant_idx == TAG_W'(gi));
      assign rsp_v[gi]  = reset && !fifo_empty && s_v && (head == TAG_W'(gi));
    end
  endgenerate

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = ptr_q;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_found && req_v[idx[TAG_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx[TAG_W-1:0];
      end
    end
  end

  // A full credit count blocks granting even when a pop lands this cycle.
  assign grant_en   = reset && (!m_v_q || m_r) && (count < CNT_MAX);
  assign grant      = grant_en && grant_found;
  assign fifo_empty = (count == '0);
  assign s_r        = reset && !fifo_empty && rsp_r[head];
  assign pop        = s_v && s_r;

  // Issue stage, arbitration pointer and sticky protocol-error next state.
  always_comb begin
    ptr_d = ptr_q;
    m_v_d = m_v_q;
    st_d  = st_q;
    cl_d  = cl_q;
    of_d  = of_q;
    err_d = err_q | (s_v && fifo_empty);
    if (grant) begin
      ptr_d = grant_idx;
      m_v_d = 1'b1;
      st_d  = st_arr[grant_idx];
      cl_d  = cl_arr[grant_idx];
      of_d  = of_arr[grant_idx];
    end else if (m_r) begin
      m_v_d = 1'b0;
    end
  end

  // Registers; reset leaves the pointer so that requester 0 wins first.
  always_ff @(posedge clk1x) begin
    if (!reset) begin
      ptr_q <= PTR_RST;
      m_v_q <= 1'b0;
      st_q  <= '0;
      cl_q  <= '0;
      of_q  <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      m_v_q <= m_v_d;
      st_q  <= st_d;
      cl_q  <= cl_d;
      of_q  <= of_d;
      err_q <= err_d;
    end
  end

  msb_tag_fifo #(
    .TAG_W (TAG_W),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk    (clk1x),
    .rst_n  (reset),
    .push   (grant),
    .tag_in (grant_idx),
    .pop    (pop),
    .head   (head),
    .count  (count)
  );

  assign m_v      = m_v_q;
  assign m_ra_st  = st_q;
  assign m_ra_cl  = cl_q;
  assign m_ra_of  = of_q;
  assign rsp_d    = s_rd;
  assign inflight = count;
  assign err      = err_q;

endmodule

// File: tb/tb_msb_read_arbiter.sv
// Directed bench for msb_read_arbiter with grant/tag scoreboards.
module tb_msb_read_arbiter;

  logic         clk1x = 1'b0;
  logic         reset;
  logic [3:0]   req_v, req_r;
  logic [15:0]  req_st, req_cl;
  logic [11:0]  req_of;
  logic         m_v, m_r;
  logic [3:0]   m_ra_st, m_ra_cl;
  logic [2:0]   m_ra_of;
  logic         s_v, s_r;
  logic [127:0] s_rd, rsp_d;
  logic [3:0]   rsp_v, rsp_r;
  logic [3:0]   inflight;
  logic         err;

  logic [3:0] st_tab [4];
  logic [3:0] cl_tab [4];
  logic [2:0] of_tab [4];

  int checks   = 0;
  int failures = 0;
  int iss_q[$];
  int tag_q[$];
  int ptr_m;

  always #5 clk1x = ~clk1x;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_st[i*4 +: 4] = st_tab[i];
      req_cl[i*4 +: 4] = cl_tab[i];
      req_of[i*3 +: 3] = of_tab[i];
    end
  end

  msb_read_arbiter dut (
    .clk1x(clk1x), .reset(reset),
    .req_v(req_v), .req_r(req_r),
    .req_st(req_st), .req_cl(req_cl), .req_of(req_of),
    .m_v(m_v), .m_r(m_r),
    .m_ra_st(m_ra_st), .m_ra_cl(m_ra_cl), .m_ra_of(m_ra_of),
    .s_v(s_v), .s_r(s_r), .s_rd(s_rd),
    .rsp_v(rsp_v), .rsp_r(rsp_r), .rsp_d(rsp_d),
    .inflight(inflight), .err(err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int p, input logic [3:0] v);
    for (int k = 1; k <= 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int i);
    return 4'(1 << i);
  endfunction

  task automatic check_issue(input string tag, input int idx);
    chk({tag, "_m_v"}, 128'(m_v), 128'(1'b1));
    chk({tag, "_st"}, 128'(m_ra_st), 128'(st_tab[idx]));
    chk({tag, "_cl"}, 128'(m_ra_cl), 128'(cl_tab[idx]));
    chk({tag, "_of"}, 128'(m_ra_of), 128'(of_tab[idx]));
    $display("issue %s: req=%0d st=%0h cl=%0h of=%0h", tag, idx, m_ra_st, m_ra_cl, m_ra_of);
  endtask

  // Expect a grant to the round-robin winner among `v` and record it.
  task automatic expect_grant(input string tag, input logic [3:0] v);
    int g;
    g = rr_pick(ptr_m, v);
    chk(tag, 128'(req_r), 128'(onehot(g)));
    $display("grant %s: req_r=%b expected=%b", tag, req_r, onehot(g));
    iss_q.push_back(g);
    tag_q.push_back(g);
    ptr_m = g;
  endtask

  // Return one read with data d; the head tag decides the routing.
  task automatic expect_response(input string tag, input logic [127:0] d);
    int h;
    h = tag_q.pop_front();
    chk({tag, "_rsp_v"}, 128'(rsp_v), 128'(onehot(h)));
    chk({tag, "_s_r"}, 128'(s_r), 128'(1'b1));
    chk({tag, "_rsp_d"}, rsp_d, d);
    $display("response %s: rsp_v=%b s_r=%b data=%h", tag, rsp_v, s_r, rsp_d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] d;
    for (int i = 0; i < 4; i++) begin
      st_tab[i] = 4'(i + 1);
      cl_tab[i] = 4'(i + 8);
      of_tab[i] = 3'(i + 2);
    end
    reset = 1'b0; req_v = '0; m_r = 1'b0; s_v = 1'b0; s_rd = '0; rsp_r = '0;
    ptr_m = 3;
    repeat (3) @(negedge clk1x);
    #1;
    chk("rst_m_v", 128'(m_v), 128'(0));
    chk("rst_m_ra_st", 128'(m_ra_st), 128'(0));
    chk("rst_m_ra_cl", 128'(m_ra_cl), 128'(0));
    chk("rst_m_ra_of", 128'(m_ra_of), 128'(0));
    chk("rst_req_r", 128'(req_r), 128'(0));
    chk("rst_s_r", 128'(s_r), 128'(0));
    chk("rst_rsp_v", 128'(rsp_v), 128'(0));
    chk("rst_inflight", 128'(inflight), 128'(0));
    chk("rst_err", 128'(err), 128'(0));

    // Round-robin fairness up to the credit limit.
    reset = 1'b1; req_v = 4'hF; m_r = 1'b1;
    #1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) check_issue("rr_issue", iss_q.pop_front());
      chk("rr_inflight", 128'(inflight), 128'(c));
      expect_grant("rr_grant", req_v);
      @(negedge clk1x); #1;
    end
    check_issue("rr_issue_last", iss_q.pop_front());
    chk("rr_full_inflight", 128'(inflight), 128'(8));
    chk("rr_full_no_grant", 128'(req_r), 128'(0));
    @(negedge clk1x); #1;
    chk("rr_drained_m_v", 128'(m_v), 128'(0));
    chk("rr_full_still", 128'(req_r), 128'(0));

    // Full boundary: a pop does not allow a grant in the same cycle.
    @(negedge clk1x);
    s_v = 1'b1; rsp_r = 4'hF; d = {4{32'hF0F0_0001}}; s_rd = d;
    #1;
    chk("full_pop_no_grant", 128'(req_r), 128'(0));
    expect_response("full_pop", d);
    @(negedge clk1x);
    s_v = 1'b0;
    #1;
    chk("full_after_pop_inflight", 128'(inflight), 128'(7));
    expect_grant("full_resume", req_v);
    @(negedge clk1x); #1;
    check_issue("full_resume_issue", iss_q.pop_front());
    chk("full_back_to_8", 128'(inflight), 128'(8));
    chk("full_again_no_grant", 128'(req_r), 128'(0));
    req_v = 4'h0;

    // Drain every outstanding read in grant order.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk1x);
      s_v = 1'b1; rsp_r = 4'hF; d = {4{32'hC0DE_0000 + 32'(k)}}; s_rd = d;
      #1;
      chk("drain_inflight", 128'(inflight), 128'(8 - k));
      expect_response("drain", d);
    end
    @(negedge clk1x);
    s_v = 1'b0;
    #1;
    chk("drain_empty", 128'(inflight), 128'(0));
    chk("drain_m_v", 128'(m_v), 128'(0));

    // Backpressure: requester 2 held in the issue stage while m_r is low.
    st_tab[2] = 4'd1; cl_tab[2] = 4'd4; of_tab[2] = 3'd0;
    @(negedge clk1x);
    req_v = 4'b0100; m_r = 1'b0;
    #1;
    expect_grant("bp_grant", req_v);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk1x); #1;
      check_issue("bp_hold", iss_q[0]);
      chk("bp_no_grant", 128'(req_r), 128'(0));
    end
    @(negedge clk1x);
    m_r = 1'b1;
    #1;
    check_issue("bp_drain", iss_q.pop_front());
    expect_grant("bp_regrant", req_v);
    @(negedge clk1x);
    req_v = 4'h0;
    #1;
    check_issue("bp_second", iss_q.pop_front());
    chk("bp_inflight", 128'(inflight), 128'(2));
    @(negedge clk1x); #1;
    chk("bp_idle_m_v", 128'(m_v), 128'(0));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk1x);
      s_v = 1'b1; rsp_r = 4'hF; d = {4{32'hBB00_0000 + 32'(k)}}; s_rd = d;
      #1;
      expect_response("bp_rsp", d);
    end
    @(negedge clk1x);
    s_v = 1'b0;
    st_tab[2] = 4'd3; cl_tab[2] = 4'd10; of_tab[2] = 3'd4;

    // Response routing with a stalled requester 3.
    req_v = 4'b0010;
    #1;
    expect_grant("route_g1", req_v);
    @(negedge clk1x);
    req_v = 4'b1000;
    #1;
    expect_grant("route_g3", req_v);
    @(negedge clk1x);
    req_v = 4'b0000;
    @(negedge clk1x);
    s_v = 1'b1; rsp_r = 4'hF; d = {4{32'hD1D1_D1D1}}; s_rd = d;
    #1;
    expect_response("route_d1", d);
    @(negedge clk1x);
    rsp_r = 4'b0111; d = {4{32'hD3D3_D3D3}}; s_rd = d;
    #1;
    chk("route_stall_rsp_v", 128'(rsp_v), 128'(4'b1000));
    chk("route_stall_s_r", 128'(s_r), 128'(0));
    chk("route_stall_d", rsp_d, d);
    $display("response route_stall: rsp_v=%b s_r=%b", rsp_v, s_r);
    @(negedge clk1x);
    #1;
    chk("route_stall_inflight", 128'(inflight), 128'(1));
    rsp_r = 4'b1000;
    #1;
    expect_response("route_d3", d);
    @(negedge clk1x);
    s_v = 1'b0;
    #1;
    chk("route_done", 128'(inflight), 128'(0));
    iss_q.delete();

    // Protocol error: data with nothing outstanding.
    @(negedge clk1x);
    s_v = 1'b1; rsp_r = 4'hF;
    #1;
    chk("perr_s_r", 128'(s_r), 128'(0));
    chk("perr_rsp_v", 128'(rsp_v), 128'(0));
    chk("perr_err_before", 128'(err), 128'(0));
    @(negedge clk1x);
    s_v = 1'b0;
    #1;
    chk("perr_err_set", 128'(err), 128'(1));
    @(negedge clk1x); #1;
    chk("perr_err_sticky", 128'(err), 128'(1));
    reset = 1'b0;
    #1;
    chk("perr_err_until_edge", 128'(err), 128'(1));
    @(negedge clk1x); #1;
    chk("perr_err_cleared", 128'(err), 128'(0));
    $display("protocol error: err=%b after reset", err);
    reset = 1'b1;
    ptr_m = 3;

    // Reset in the middle of a burst.
    req_v = 4'hF; m_r = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      expect_grant("burst_grant", req_v);
      @(negedge clk1x); #1;
    end
    chk("burst_inflight", 128'(inflight), 128'(5));
    reset = 1'b0;
    #1;
    chk("burst_rst_req_r", 128'(req_r), 128'(0));
    @(negedge clk1x); #1;
    chk("burst_rst_inflight", 128'(inflight), 128'(0));
    chk("burst_rst_m_v", 128'(m_v), 128'(0));
    chk("burst_rst_st", 128'(m_ra_st), 128'(0));
    iss_q.delete(); tag_q.delete();
    ptr_m = 3;
    reset = 1'b1;
    #1;
    expect_grant("post_rst_grant", req_v);
    @(negedge clk1x);
    req_v = 4'h0;
    #1;
    check_issue("post_rst_issue", iss_q.pop_front());
    chk("post_rst_inflight", 128'(inflight), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
